// File: rtl/serializador.sv
// rtl/serializador.sv - 8-bit parallel-to-serial transmitter with a one-entry input buffer and idle K fill
// Define SERDES_PARITY_EN for 9-bit frames that end in an even-parity bit over {byte, DK}.
module serializador #(
  parameter logic [7:0] IDLE_SYM = 8'hBC,
  parameter logic       IDLE_DK  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       in_DK,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       data,
  output logic       out_DK,
  output logic       frame_start
);

`ifdef SERDES_PARITY_EN
  localparam int            CW   = 4;
  localparam logic [CW-1:0] LAST = 4'd8;
`else
  localparam int            CW   = 3;
  localparam logic [CW-1:0] LAST = 3'd7;
`endif

  logic [CW-1:0] r_bit_cnt;
  logic [7:0]    r_shreg;
  logic [7:0]    r_buf_data;
  logic          r_buf_dk;
  logic          r_buf_full;
  logic          r_data;
  logic          r_out_dk;
  logic          r_frame_start;

  logic          w_boundary;
  logic          w_accept;
  logic [7:0]    w_load_byte;
  logic          w_load_dk;
  logic          w_next_bit;

  assign w_boundary  = (r_bit_cnt == LAST);
  // The buffer drains on a boundary edge, so a write can land on that same edge.
  assign in_ready    = !r_buf_full || w_boundary;
  assign w_accept    = in_valid && in_ready;
  assign w_load_byte = r_buf_full ? r_buf_data : IDLE_SYM;
  assign w_load_dk   = r_buf_full ? r_buf_dk   : IDLE_DK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_data <= '0;
      r_buf_dk   <= 1'b0;
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_data <= in;
      r_buf_dk   <= in_DK;
      r_buf_full <= 1'b1;
    end else if (w_boundary) begin
      r_buf_full <= 1'b0;
    end
  end

`ifdef SERDES_PARITY_EN
  localparam logic [CW-1:0] PAR_CNT = 4'd7;
  logic r_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_boundary) begin
      r_parity <= ^{w_load_byte, w_load_dk};
    end
  end

  assign w_next_bit = (r_bit_cnt == PAR_CNT) ? r_parity : r_shreg[6];
`else
  assign w_next_bit = r_shreg[6];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt     <= LAST;
      r_shreg       <= '0;
      r_data        <= 1'b0;
      r_out_dk      <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_boundary) begin
      r_bit_cnt     <= '0;
      r_shreg       <= w_load_byte;
      r_data        <= w_load_byte[7];
      r_out_dk      <= w_load_dk;
      r_frame_start <= 1'b1;
    end else begin
      r_bit_cnt     <= r_bit_cnt + 1'b1;
      r_shreg       <= r_shreg << 1;
      r_data        <= w_next_bit;
      r_frame_start <= 1'b0;
    end
  end

  assign data        = r_data;
  assign out_DK      = r_out_dk;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_serializador.sv
// tb/tb_serializador.sv - randomized and directed bench for serializador against a frame-level model
// Build with SERDES_PARITY_EN defined to exercise 9-bit parity frames.
`timescale 1ns/1ps
module tb_serializador;

`ifdef SERDES_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in = 8'h00;
  logic       in_DK = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       data;
  logic       out_DK;
  logic       frame_start;

  serializador dut (
    .clk(clk), .reset(reset), .in(in), .in_DK(in_DK), .in_valid(in_valid),
    .in_ready(in_ready), .data(data), .out_DK(out_DK), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: expected per-cycle output triples {frame_start, DK, data}, plus the pending word.
  logic [2:0] exp_q[$];
  bit         pend_v = 1'b0;
  logic [7:0] pend_b = 8'h00;
  logic       pend_k = 1'b0;
  int         e = 0;

  // Frames reassembled from the DUT's serial output.
  int         cyc = 0;
  int         rst_cyc = 0;
  int         first_fs = -1;
  int         last_fs = -1;
  int         last_spacing = 0;
  int         cur_cnt = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] fr_b[$];
  logic       fr_k[$];
  logic       fr_p[$];
  int         not_ready_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_frame(input logic [7:0] b, input logic k);
    for (int i = 7; i >= 0; i--) exp_q.push_back({(i == 7), k, b[i]});
`ifdef SERDES_PARITY_EN
    exp_q.push_back({1'b0, k, ^{b, k}});
`endif
  endtask

  task automatic capture();
    if (frame_start) begin
      if (last_fs >= 0) last_spacing = cyc - last_fs;
      if (first_fs < 0) first_fs = cyc;
      last_fs  = cyc;
      cur_byte = {7'b0, data};
      cur_cnt  = 1;
    end else if (cur_cnt >= 1 && cur_cnt < 8) begin
      cur_byte = {cur_byte[6:0], data};
      cur_cnt++;
      if (cur_cnt == 8) begin
        fr_b.push_back(cur_byte);
        fr_k.push_back(out_DK);
      end
    end else if (cur_cnt == 8) begin
      fr_p.push_back(data);
      cur_cnt = 0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic k, output bit acc);
    bit         bnd;
    bit         exp_rdy;
    logic [2:0] x;
    @(negedge clk);
    in_valid = v;
    in       = b;
    in_DK    = k;
    bnd      = (e % FL == 0);
    exp_rdy  = !pend_v || bnd;
    chk("in_ready", in_ready, exp_rdy);
    if (!in_ready) not_ready_cycles++;
    acc = v && exp_rdy;
    @(posedge clk);
    if (bnd) begin
      if (pend_v) push_frame(pend_b, pend_k);
      else        push_frame(8'hBC, 1'b1);
      pend_v = 1'b0;
    end
    if (acc) begin
      pend_v = 1'b1;
      pend_b = b;
      pend_k = k;
    end
    e++;
    cyc++;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL model_underflow: no expected bit at cycle %0d, data=%0b required=defined", cyc, data);
    end else begin
      x = exp_q.pop_front();
      chk("frame_start", frame_start, x[2]);
      chk("out_DK", out_DK, x[1]);
      chk("data", data, x[0]);
    end
    capture();
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic send(input logic [7:0] b, input logic k);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 40) begin
      step(1'b1, b, k, a);
      n++;
    end
    if (!a) begin
      checks++;
      $display("FAIL accept_timeout: byte %0h accepted=0, required=1 within 40 cycles", b);
    end
  endtask

  task automatic clear_frames();
    fr_b.delete();
    fr_k.delete();
    fr_p.delete();
  endtask

  task automatic sync_boundary();
    bit a;
    int n = 0;
    while (e % FL != 0 && n < 20) begin
      step(1'b0, 8'h00, 1'b0, a);
      n++;
    end
    clear_frames();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_data", data, 0);
    chk("rst_out_DK", out_DK, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    pend_v   = 1'b0;
    e        = 0;
    cur_cnt  = 0;
    last_fs  = -1;
    first_fs = -1;
    rst_cyc  = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 required=1");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         a;
    bit         hold_v = 1'b0;
    logic [7:0] hb = 8'h00;
    logic       hk = 1'b0;
    int         nr0;
    int         n0f;

    // Reset then idle
    do_reset();
    clear_frames();
    idle(3 * FL);
    chk("idle_first_fs_delay", first_fs - rst_cyc, 1);
    chk("idle_frame_count", fr_b.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("idle_byte", fr_b[i], 8'hBC);
      chk("idle_dk", fr_k[i], 1);
    end
    chk("idle_spacing", last_spacing, FL);

    // Single word mid-frame
    sync_boundary();
    idle(3);
    send(8'hA5, 1'b0);
    idle(3 * FL - 4);
    chk("single_pre_idle", fr_b[0], 8'hBC);
    chk("single_byte", fr_b[1], 8'hA5);
    chk("single_dk", fr_k[1], 0);
    chk("single_post_idle", fr_b[2], 8'hBC);
    chk("single_post_dk", fr_k[2], 1);

    // Back-to-back stream
    sync_boundary();
    nr0 = not_ready_cycles;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    idle(3 * FL - 1);
    chk("stream_f0", fr_b[0], 8'hBC);
    chk("stream_f1", fr_b[1], 8'h01);
    chk("stream_f2", fr_b[2], 8'h02);
    chk("stream_f3", fr_b[3], 8'h03);
    chk("stream_f4", fr_b[4], 8'hBC);
    chk("stream_not_ready", not_ready_cycles - nr0, 3 * (FL - 1));

    // Accept on a boundary edge while the buffer is full
    sync_boundary();
    send(8'h55, 1'b0);
    idle(FL - 1);
    send(8'h3C, 1'b1);
    idle(3 * FL - 1);
    chk("bnd_f1", fr_b[1], 8'h55);
    chk("bnd_f1_dk", fr_k[1], 0);
    chk("bnd_f2", fr_b[2], 8'h3C);
    chk("bnd_f2_dk", fr_k[2], 1);
    chk("bnd_f3", fr_b[3], 8'hBC);

    // Reset mid-frame with a word buffered
    sync_boundary();
    send(8'hF0, 1'b0);
    idle(FL - 1);
    send(8'h0F, 1'b0);
    idle(4);
    do_reset();
    clear_frames();
    idle(2 * FL);
    chk("rstmid_first", fr_b[0], 8'hBC);
    chk("rstmid_first_dk", fr_k[0], 1);
    n0f = 0;
    foreach (fr_b[i]) if (fr_b[i] == 8'h0F) n0f++;
    chk("rstmid_discarded", n0f, 0);

`ifdef SERDES_PARITY_EN
    sync_boundary();
    send(8'h07, 1'b0);
    idle(3 * FL - 1);
    chk("par_byte", fr_b[1], 8'h07);
    chk("par_bit", fr_p[1], 1);
    chk("par_idle_bit", fr_p[0], 0);
    chk("par_spacing", last_spacing, 9);
`endif

    // Randomized traffic with a source that holds each word until accepted
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if (!hold_v && $urandom_range(0, 2) == 0) begin
        hold_v = 1'b1;
        hb     = 8'($urandom);
        hk     = 1'($urandom_range(0, 1));
      end
      step(hold_v, hold_v ? hb : 8'h00, hold_v ? hk : 1'b0, a);
      if (a) hold_v = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
